bus_stim_sequencer: RTL and testbench

BUS_STIM_SEQUENCER -- requirements
Module: bus_stim_sequencer

---
 rtl/bus_seq_pkg.sv | 60 ++++++
 rtl/bus_seq_step_ram.sv | 23 ++
 rtl/bus_stim_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_bus_stim_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_seq_pkg.sv
// rtl/bus_seq_pkg.sv - shared FSM states, burst codes and step-word layout helpers
package bus_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DELAY,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_INCR   = 3'd1;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int mid_w(input int nm);
    return clog2_min1(nm);
  endfunction

  // Step word, LSB upwards: data, addr, delay, burst, read_en, master id, nowait, last.
  function automatic int f_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int f_dly_lsb(input int dw, input int aw);
    return dw + aw;
  endfunction

  function automatic int f_burst_lsb(input int dw, input int aw, input int dlyw);
    return dw + aw + dlyw;
  endfunction

  function automatic int f_rd_bit(input int dw, input int aw, input int dlyw);
    return f_burst_lsb(dw, aw, dlyw) + 3;
  endfunction

  function automatic int f_mid_lsb(input int dw, input int aw, input int dlyw);
    return f_rd_bit(dw, aw, dlyw) + 1;
  endfunction

  function automatic int f_nowait_bit(input int nm, input int dw, input int aw, input int dlyw);
    return f_mid_lsb(dw, aw, dlyw) + mid_w(nm);
  endfunction

  function automatic int f_last_bit(input int nm, input int dw, input int aw, input int dlyw);
    return f_nowait_bit(nm, dw, aw, dlyw) + 1;
  endfunction

  function automatic int step_w(input int nm, input int dw, input int aw, input int dlyw);
    return f_last_bit(nm, dw, aw, dlyw) + 1;
  endfunction

endpackage

// File: rtl/bus_seq_step_ram.sv
// rtl/bus_seq_step_ram.sv - step table, one write port, asynchronous read, no reset
module bus_seq_step_ram #(
  parameter int DEPTH  = 16,
  parameter int STEP_W = 33,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [STEP_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [STEP_W-1:0] o_rdata
);

  logic [STEP_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_stim_sequencer.sv
// rtl/bus_stim_sequencer.sv - programmable multi-master bus stimulus sequencer
// Optional drain watchdog enabled by defining SEQ_DRAIN_TIMEOUT_EN.
module bus_stim_sequencer
  import bus_seq_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 14,
  parameter int DEPTH          = 16,
  parameter int HOLD_CYCLES    = 3,
  parameter int DLY_W          = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDX_W  = clog2_min1(DEPTH),
  localparam int STEP_W = step_w(NUM_MASTERS, DATA_W, ADDR_W, DLY_W)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [IDX_W-1:0]              prog_addr,
  input  logic [STEP_W-1:0]             prog_data,
  input  logic [NUM_MASTERS-1:0]        m_request,
  output logic [NUM_MASTERS-1:0]        m_enable,
  output logic [NUM_MASTERS-1:0]        m_read_en,
  output logic [3*NUM_MASTERS-1:0]      m_burst_mode,
  output logic [DATA_W*NUM_MASTERS-1:0] m_data,
  output logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_W-1:0]              step_idx,
  output logic                          error
);

  localparam int MID_W      = mid_w(NUM_MASTERS);
  localparam int ADDR_LSB   = f_addr_lsb(DATA_W);
  localparam int DLY_LSB    = f_dly_lsb(DATA_W, ADDR_W);
  localparam int BURST_LSB  = f_burst_lsb(DATA_W, ADDR_W, DLY_W);
  localparam int RD_BIT     = f_rd_bit(DATA_W, ADDR_W, DLY_W);
  localparam int MID_LSB    = f_mid_lsb(DATA_W, ADDR_W, DLY_W);
  localparam int NOWAIT_BIT = f_nowait_bit(NUM_MASTERS, DATA_W, ADDR_W, DLY_W);
  localparam int LAST_BIT   = f_last_bit(NUM_MASTERS, DATA_W, ADDR_W, DLY_W);
  // One counter serves hold, delay and watchdog phases.
  localparam int CNT_W = clog2_min1(max_int(max_int(HOLD_CYCLES, TIMEOUT_CYCLES), 1 << DLY_W) + 1);

  seq_state_e r_state, w_next_state;

  logic [STEP_W-1:0] w_rd_step;
  logic [IDX_W-1:0]  w_load_idx, r_step_idx;
  logic              w_prog_we;
  logic [DATA_W-1:0] w_f_data;
  logic [ADDR_W-1:0] w_f_addr;
  logic [DLY_W-1:0]  w_f_dly;
  logic [2:0]        w_f_burst;
  logic              w_f_rd, w_f_nowait, w_f_last;
  logic [MID_W-1:0]  w_f_mid;

  logic [CNT_W-1:0]  r_cnt, w_cnt_inc;
  logic              r_cur_last, r_cur_nowait;
  logic [DLY_W-1:0]  r_cur_dly;
  logic              w_last_eff, w_go_drain, w_load, w_cnt_clr;

  logic [NUM_MASTERS-1:0]        r_m_enable, r_m_read_en;
  logic [3*NUM_MASTERS-1:0]      r_m_burst;
  logic [DATA_W*NUM_MASTERS-1:0] r_m_data;
  logic [ADDR_W*NUM_MASTERS-1:0] r_m_addr;

  assign w_prog_we  = prog_we && (r_state == S_IDLE);
  assign w_load_idx = (r_state == S_IDLE) ? '0 : r_step_idx + IDX_W'(1);

  bus_seq_step_ram #(
    .DEPTH  (DEPTH),
    .STEP_W (STEP_W),
    .IDX_W  (IDX_W)
  ) u_step_ram (
    .clk     (clk),
    .i_we    (w_prog_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_load_idx),
    .o_rdata (w_rd_step)
  );

  assign w_f_data   = w_rd_step[DATA_W-1:0];
  assign w_f_addr   = w_rd_step[ADDR_LSB +: ADDR_W];
  assign w_f_dly    = w_rd_step[DLY_LSB +: DLY_W];
  assign w_f_burst  = w_rd_step[BURST_LSB +: 3];
  assign w_f_rd     = w_rd_step[RD_BIT];
  assign w_f_mid    = w_rd_step[MID_LSB +: MID_W];
  assign w_f_nowait = w_rd_step[NOWAIT_BIT];
  assign w_f_last   = w_rd_step[LAST_BIT];

  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_last_eff = r_cur_last || (r_step_idx == IDX_W'(DEPTH - 1));
  assign w_go_drain = !r_cur_nowait || w_last_eff;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_cnt_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_ISSUE;
          w_load       = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_cnt_inc == CNT_W'(HOLD_CYCLES)) begin
          if (r_cur_dly != '0) begin
            w_next_state = S_DELAY;
            w_cnt_clr    = 1'b1;
          end else if (w_go_drain) begin
            w_next_state = S_DRAIN;
            w_cnt_clr    = 1'b1;
          end else begin
            w_next_state = S_ISSUE;
            w_load       = 1'b1;
          end
        end
      end
      S_DELAY: begin
        if (w_cnt_inc == CNT_W'(r_cur_dly)) begin
          if (w_go_drain) begin
            w_next_state = S_DRAIN;
            w_cnt_clr    = 1'b1;
          end else begin
            w_next_state = S_ISSUE;
            w_load       = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (m_request == '0) begin
          if (w_last_eff) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_ISSUE;
            w_load       = 1'b1;
          end
        end
`ifdef SEQ_DRAIN_TIMEOUT_EN
        else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          w_next_state = S_DONE;
        end
`endif
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Master slices keep their last issued values until that master is issued again.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_idx   <= '0;
      r_cnt        <= '0;
      r_cur_last   <= 1'b0;
      r_cur_nowait <= 1'b0;
      r_cur_dly    <= '0;
      r_m_enable   <= '0;
      r_m_read_en  <= '0;
      r_m_burst    <= {NUM_MASTERS{BURST_SINGLE}};
      r_m_data     <= '0;
      r_m_addr     <= '0;
    end else begin
      if (w_load || w_cnt_clr) r_cnt <= '0;
      else                     r_cnt <= w_cnt_inc;

      if (w_load) begin
        r_step_idx   <= w_load_idx;
        r_cur_last   <= w_f_last;
        r_cur_nowait <= w_f_nowait;
        r_cur_dly    <= w_f_dly;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          r_m_enable[i] <= (int'(w_f_mid) == i);
          if (int'(w_f_mid) == i) begin
            r_m_read_en[i]              <= w_f_rd;
            r_m_burst[i*3 +: 3]         <= w_f_burst;
            r_m_data[i*DATA_W +: DATA_W] <= w_f_data;
            r_m_addr[i*ADDR_W +: ADDR_W] <= w_f_addr;
          end
        end
      end else if (w_next_state != S_ISSUE) begin
        r_m_enable <= '0;
      end
    end
  end

`ifdef SEQ_DRAIN_TIMEOUT_EN
  logic r_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_error <= 1'b0;
    end else if (r_state == S_DRAIN && w_next_state == S_DONE && m_request != '0) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign m_enable     = r_m_enable;
  assign m_read_en    = r_m_read_en;
  assign m_burst_mode = r_m_burst;
  assign m_data       = r_m_data;
  assign m_addr       = r_m_addr;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign step_idx     = r_step_idx;

endmodule

// File: tb/tb_bus_stim_sequencer.sv
// tb/tb_bus_stim_sequencer.sv - self-checking bench: vector table, directed corners, random vs timeline model
module tb_bus_stim_sequencer;

  localparam int NM = 2, DW = 8, AW = 14, DEPTH = 16, IW = 4, SW = 33, H = 3, MAXC = 1024;

  logic            clk = 1'b0;
  logic            reset, start, prog_we;
  logic [IW-1:0]   prog_addr;
  logic [SW-1:0]   prog_data;
  logic [NM-1:0]   m_request;
  logic [NM-1:0]   m_enable, m_read_en;
  logic [3*NM-1:0] m_burst_mode;
  logic [DW*NM-1:0] m_data;
  logic [AW*NM-1:0] m_addr;
  logic            busy, done, error;
  logic [IW-1:0]   step_idx;

  bus_stim_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .m_request(m_request), .m_enable(m_enable), .m_read_en(m_read_en),
    .m_burst_mode(m_burst_mode), .m_data(m_data), .m_addr(m_addr), .busy(busy), .done(done),
    .step_idx(step_idx), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] mk_step(input logic last, input logic nowait, input logic mid,
      input logic rd, input logic [2:0] burst, input logic [3:0] dly, input logic [AW-1:0] addr,
      input logic [DW-1:0] data);
    return {last, nowait, mid, rd, burst, dly, addr, data};
  endfunction

  task automatic prog(input int idx, input logic [SW-1:0] w);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = IW'(idx);
    prog_data = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Master 0 request held for r cycles counted from the first enable cycle.
  task automatic run_single(input int r, input bit disturb, output int done_c, output int en_cnt,
      output logic [AW-1:0] a0, output logic [DW-1:0] d0, output logic e0, output logic ed);
    done_c = -1; en_cnt = 0; a0 = '0; d0 = '0; e0 = 1'b0; ed = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 400 && done_c < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      prog_we = 1'b0;
      if (disturb && c == 1) begin
        start = 1'b1;
        prog_we = 1'b1;
        prog_addr = '0;
        prog_data = mk_step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 14'd777, 8'd3);
      end
      if (m_enable[0]) en_cnt++;
      if (c == 0) begin
        a0 = m_addr[AW-1:0];
        d0 = m_data[DW-1:0];
        e0 = error;
      end
      if (done) begin
        done_c = c;
        ed = error;
      end
      m_request = {1'b0, (c < r)};
    end
    @(negedge clk);
    start = 1'b0;
    prog_we = 1'b0;
    m_request = '0;
  endtask

  typedef struct {
    logic       last, nowait, mid, rd;
    logic [2:0] burst;
    int         dly;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int         r;
  } step_t;

  step_t tbl[DEPTH];
  logic [NM-1:0] exp_en[MAXC];
  logic [NM-1:0] req_a[MAXC];
  logic          exp_done[MAXC], exp_busy[MAXC];
  logic [IW-1:0] exp_idx[MAXC];
  int            iss_t[DEPTH];
  int            n_iss, end_c;
  logic [AW-1:0] mdl_addr[NM];
  logic [DW-1:0] mdl_data[NM];
  logic          mdl_rd[NM];
  logic [2:0]    mdl_burst[NM];

  // Timeline model: issue k occupies [T_k, T_k+H), delay follows, then either the next
  // issue (nowait, not last) or a drain until every request window has closed.
  task automatic build_model();
    int t, k, cc, done_c;
    bit lastf;
    for (int c = 0; c < MAXC; c++) begin
      exp_en[c] = '0; req_a[c] = '0; exp_done[c] = 1'b0; exp_busy[c] = 1'b0; exp_idx[c] = '0;
    end
    t = 0; k = 0; done_c = -1; n_iss = 0;
    while (done_c < 0) begin
      lastf = tbl[k].last || (k == DEPTH - 1);
      iss_t[k] = t;
      n_iss = k + 1;
      for (int c = t; c < MAXC; c++) exp_idx[c] = IW'(k);
      for (int c = t; c < t + H; c++) exp_en[c][tbl[k].mid] = 1'b1;
      for (int c = t; c < t + tbl[k].r && c < MAXC; c++) req_a[c][tbl[k].mid] = 1'b1;
      cc = t + H + tbl[k].dly;
      if (tbl[k].nowait && !lastf) begin
        t = cc;
      end else begin
        while (cc < MAXC - 3 && req_a[cc] != '0) cc++;
        if (lastf) done_c = cc + 1;
        else t = cc + 1;
      end
      k++;
    end
    for (int c = 0; c <= done_c; c++) exp_busy[c] = 1'b1;
    exp_done[done_c] = 1'b1;
    end_c = done_c + 2;
  endtask

  task automatic run_random(input bit no_last);
    logic [AW*NM-1:0] ea;
    logic [DW*NM-1:0] ed;
    logic [NM-1:0]    er;
    logic [3*NM-1:0]  eb;
    int m;
    for (int k = 0; k < DEPTH; k++) begin
      tbl[k].last   = no_last ? 1'b0 : ($urandom_range(0, 3) == 0);
      tbl[k].nowait = 1'($urandom_range(0, 1));
      tbl[k].mid    = 1'($urandom_range(0, 1));
      tbl[k].rd     = 1'($urandom_range(0, 1));
      tbl[k].burst  = 3'($urandom_range(0, 7));
      tbl[k].dly    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0;
      tbl[k].addr   = AW'($urandom);
      tbl[k].data   = DW'($urandom);
      tbl[k].r      = int'($urandom_range(0, 8));
      prog(k, mk_step(tbl[k].last, tbl[k].nowait, tbl[k].mid, tbl[k].rd, tbl[k].burst,
                      4'(tbl[k].dly), tbl[k].addr, tbl[k].data));
    end
    build_model();
    @(negedge clk);
    start = 1'b1;
    m_request = '0;
    for (int c = 0; c < end_c; c++) begin
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < n_iss; k++) begin
        if (iss_t[k] == c) begin
          m = int'(tbl[k].mid);
          mdl_addr[m] = tbl[k].addr; mdl_data[m] = tbl[k].data;
          mdl_rd[m] = tbl[k].rd; mdl_burst[m] = tbl[k].burst;
        end
      end
      for (int i = 0; i < NM; i++) begin
        ea[i*AW +: AW] = mdl_addr[i]; ed[i*DW +: DW] = mdl_data[i];
        er[i] = mdl_rd[i]; eb[i*3 +: 3] = mdl_burst[i];
      end
      check("rnd_enable", 64'(m_enable), 64'(exp_en[c]));
      check("rnd_done", 64'(done), 64'(exp_done[c]));
      check("rnd_busy", 64'(busy), 64'(exp_busy[c]));
      check("rnd_step_idx", 64'(step_idx), 64'(exp_idx[c]));
      check("rnd_addr", 64'(m_addr), 64'(ea));
      check("rnd_data", 64'(m_data), 64'(ed));
      check("rnd_read_en", 64'(m_read_en), 64'(er));
      check("rnd_burst", 64'(m_burst_mode), 64'(eb));
      m_request = req_a[c];
    end
    m_request = '0;
    check("rnd_error", 64'(error), 64'd0);
  endtask

  typedef struct {
    int dly;
    bit nowait;
    int r;
    int exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dc, en, rise0, rise1, nb;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic e0, ed;
    logic [AW*NM-1:0] av;
    logic [NM-1:0] rv;

    vecs[0] = '{dly: 0,  nowait: 1'b0, r: 5,  exp_done: 6};
    vecs[1] = '{dly: 0,  nowait: 1'b0, r: 0,  exp_done: 4};
    vecs[2] = '{dly: 2,  nowait: 1'b0, r: 0,  exp_done: 6};
    vecs[3] = '{dly: 8,  nowait: 1'b0, r: 3,  exp_done: 12};
    vecs[4] = '{dly: 1,  nowait: 1'b0, r: 9,  exp_done: 10};
    vecs[5] = '{dly: 4,  nowait: 1'b1, r: 0,  exp_done: 8};
    vecs[6] = '{dly: 15, nowait: 1'b0, r: 20, exp_done: 21};

    reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; m_request = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    check("reset_enable", 64'(m_enable), 64'd0);
    check("reset_addr", 64'(m_addr), 64'd0);
    check("reset_step_idx", 64'(step_idx), 64'd0);

    for (int v = 0; v < 7; v++) begin
      prog(0, mk_step(1'b1, vecs[v].nowait, 1'b0, 1'b0, 3'd1, 4'(vecs[v].dly), 14'd5012, 8'd78));
      run_single(vecs[v].r, 1'b0, dc, en, a0, d0, e0, ed);
      check("vec_done_cycle", 64'(dc), 64'(vecs[v].exp_done));
      check("vec_enable_cycles", 64'(en), 64'd3);
      check("vec_addr", 64'(a0), 64'd5012);
      check("vec_data", 64'(d0), 64'd78);
    end

    // Overlapped issue: nowait step 0 with delay 8 hands straight to step 1 on master 1.
    prog(0, mk_step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd8, 14'd5012, 8'd78));
    prog(1, mk_step(1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 4'd0, 14'd1001, 8'd0));
    rise0 = -1; rise1 = -1; dc = -1; nb = 0; av = '0; rv = '0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 100 && dc < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_enable[0] && rise0 < 0) rise0 = c;
      if (m_enable[1] && rise1 < 0) begin
        rise1 = c; av = m_addr; rv = m_read_en;
      end
      if (!busy) nb++;
      if (done) dc = c;
    end
    @(negedge clk);
    check("ovl_rise0", 64'(rise0), 64'd0);
    check("ovl_gap", 64'(rise1 - rise0), 64'd11);
    check("ovl_addr0_held", 64'(av[AW-1:0]), 64'd5012);
    check("ovl_addr1", 64'(av[2*AW-1:AW]), 64'd1001);
    check("ovl_read_en", 64'(rv), 64'd2);
    check("ovl_done_cycle", 64'(dc), 64'd15);
    check("ovl_busy_gaps", 64'(nb), 64'd0);

    // Reset while in ISSUE, then replay from the untouched table.
    prog(0, mk_step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 14'd5012, 8'd78));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_enable_before", 64'(m_enable), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_enable", 64'(m_enable), 64'd0);
    check("rst_mid_addr", 64'(m_addr), 64'd0);
    check("rst_mid_data", 64'(m_data), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_step_idx", 64'(step_idx), 64'd0);
    run_single(0, 1'b0, dc, en, a0, d0, e0, ed);
    check("rst_replay_addr", 64'(a0), 64'd5012);
    check("rst_replay_done", 64'(dc), 64'd4);

    // start and prog_we while busy are ignored.
    run_single(5, 1'b1, dc, en, a0, d0, e0, ed);
    check("busy_ign_done", 64'(dc), 64'd6);
    check("busy_ign_enable_cycles", 64'(en), 64'd3);
    run_single(0, 1'b0, dc, en, a0, d0, e0, ed);
    check("busy_ign_replay_addr", 64'(a0), 64'd5012);
    check("busy_ign_replay_data", 64'(d0), 64'd78);

`ifdef SEQ_DRAIN_TIMEOUT_EN
    run_single(1000, 1'b0, dc, en, a0, d0, e0, ed);
    check("timeout_done_cycle", 64'(dc), 64'd258);
    check("timeout_error", 64'(ed), 64'd1);
    check("timeout_error_sticky", 64'(error), 64'd1);
    run_single(0, 1'b0, dc, en, a0, d0, e0, ed);
    check("timeout_error_cleared", 64'(e0), 64'd0);
`else
    run_single(300, 1'b0, dc, en, a0, d0, e0, ed);
    check("long_drain_done_cycle", 64'(dc), 64'd301);
    check("long_drain_error", 64'(ed), 64'd0);
`endif

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NM; i++) begin
      mdl_addr[i] = '0; mdl_data[i] = '0; mdl_rd[i] = 1'b0; mdl_burst[i] = 3'd0;
    end
    for (int t = 0; t < 24; t++) run_random(t == 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
